// File: rtl/uart8_tx_buffered.sv
// ============================================================================
// uart8_tx_buffered : 8N1 UART transmitter fed by a small byte FIFO
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart8_tx_buffered #(
  parameter int CLOCK_RATE = 12000000,
  parameter int BAUD_RATE  = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              txEn,
  input  logic                              wrEn,
  input  logic [7:0]                        in,
  output logic                              out,
  output logic                              txBusy,
  output logic                              txDone,
  output logic                              full,
  output logic                              empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count
);

  localparam int CLKS_PER_BIT = CLOCK_RATE / BAUD_RATE;
  localparam int CW   = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int AW   = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNTW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0]   LAST_CLK  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CNTW-1:0] FULL_CNT  = CNTW'(FIFO_DEPTH);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
      $error("uart8_tx_buffered: CLOCK_RATE/BAUD_RATE must be at least 2");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_fifo_depth
      $error("uart8_tx_buffered: FIFO_DEPTH must be a power of two, at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_clk_cnt;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift;
  logic            r_out;
  logic            r_busy;
  logic            r_done;

  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CNTW-1:0] r_count;
  logic            r_full;
  logic            r_empty;

  logic            w_stop_last;
  logic            w_pop;
  logic            w_push;
  logic [CNTW-1:0] w_count_nxt;
  logic            w_line;

  // A pop only launches a frame, so it is tied to the two transitions into START.
  assign w_stop_last = (r_state == ST_STOP) && (r_clk_cnt == LAST_CLK);
  assign w_pop       = txEn && !r_empty && ((r_state == ST_IDLE) || w_stop_last);
  assign w_push      = wrEn && (!r_full || w_pop);
  assign w_count_nxt = r_count + CNTW'(w_push) - CNTW'(w_pop);

  always_comb begin
    w_line = 1'b1;
    case (r_state)
      ST_START: w_line = 1'b0;
      ST_DATA:  w_line = r_shift[0];
      default:  w_line = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == FULL_CNT);
      r_empty <= (w_count_nxt == '0);
    end
  end

  // Line outputs trail the state by one register, so out, txBusy and txDone stay aligned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_out     <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_out  <= w_line;
      r_busy <= (r_state != ST_IDLE);
      r_done <= w_stop_last;
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_shift   <= r_mem[r_rd_ptr];
            r_clk_cnt <= '0;
            r_state   <= ST_START;
          end
        end
        ST_START: begin
          if (r_clk_cnt == LAST_CLK) begin
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_state   <= ST_DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + CW'(1);
          end
        end
        ST_DATA: begin
          if (r_clk_cnt == LAST_CLK) begin
            r_clk_cnt <= '0;
            r_shift   <= {1'b0, r_shift[7:1]};
            if (r_bit_idx == 3'd7) begin
              r_state <= ST_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + CW'(1);
          end
        end
        ST_STOP: begin
          if (r_clk_cnt == LAST_CLK) begin
            r_clk_cnt <= '0;
            if (w_pop) begin
              r_shift <= r_mem[r_rd_ptr];
              r_state <= ST_START;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign out    = r_out;
  assign txBusy = r_busy;
  assign txDone = r_done;
  assign full   = r_full;
  assign empty  = r_empty;
  assign count  = r_count;

endmodule

`default_nettype wire
